// File: rtl/tick_irq_ctrl_pkg.sv
// Shared types for the tick interrupt controller: the 32-bit word and the
// controller state encoding.
package tick_irq_ctrl_pkg;

   typedef logic [31:0] word;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ARM
   } tick_irq_state_e;

endpackage

// File: rtl/tick_irq_ctrl_sat_counter.sv
// Saturating up-counter with clear. A clear takes priority over the held count,
// but an increment in the same cycle still lands on the freshly cleared value.
module tick_irq_ctrl_sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = WIDTH'(inc_i);
      end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tick_irq_ctrl.sv
// Consumes the timekeeper's sticky tick, re-arms it for one cycle per tick,
// divides ticks into a level interrupt with ack, and tracks overruns.
module tick_irq_ctrl
   import tick_irq_ctrl_pkg::*;
#(
   parameter word         TICKS_PER_IRQ = 32'd4,
   parameter int unsigned OVR_W         = 8
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             en_i,
   input  logic             tick_i,
   output logic             timer_res_o,
   output logic             irq_o,
   input  logic             irq_ack_i,
   output logic             overrun_o,
   input  logic             ovr_clr_i,
   output logic [OVR_W-1:0] ovr_cnt_o,
   output word              tick_total_o
);

   tick_irq_state_e state_d, state_q;
   logic            timer_res_d, timer_res_q;
   logic            irq_d, irq_q;
   logic            overrun_d, overrun_q;
   word             div_cnt_d, div_cnt_q;
   word             tick_total_d, tick_total_q;
   logic            fire;
   logic            ovr_event;

   // timer_res_d is the value for the state being entered, so the re-arm
   // pulse lines up exactly with the single ARM cycle.
   always_comb begin
      state_d      = state_q;
      timer_res_d  = timer_res_q;
      div_cnt_d    = div_cnt_q;
      tick_total_d = tick_total_q;
      irq_d        = irq_q;
      overrun_d    = overrun_q;
      fire         = 1'b0;
      ovr_event    = 1'b0;

      case (state_q)
         IDLE: begin
            timer_res_d = 1'b1;
            if (en_i) begin
               state_d     = RUN;
               timer_res_d = 1'b0;
            end
         end
         RUN: begin
            timer_res_d = 1'b0;
            if (!en_i) begin
               state_d     = IDLE;
               timer_res_d = 1'b1;
               div_cnt_d   = '0;
            end else if (tick_i) begin
               state_d      = ARM;
               timer_res_d  = 1'b1;
               tick_total_d = tick_total_q + 32'd1;
               if (div_cnt_q == TICKS_PER_IRQ - 32'd1) begin
                  div_cnt_d = '0;
                  fire      = 1'b1;
               end else begin
                  div_cnt_d = div_cnt_q + 32'd1;
               end
            end
         end
         ARM: begin
            if (en_i) begin
               state_d     = RUN;
               timer_res_d = 1'b0;
            end else begin
               state_d     = IDLE;
               timer_res_d = 1'b1;
               div_cnt_d   = '0;
            end
         end
         default: begin
            state_d     = IDLE;
            timer_res_d = 1'b1;
            div_cnt_d   = '0;
         end
      endcase

      if (fire) begin
         if (!irq_q || irq_ack_i) begin
            irq_d = 1'b1;
         end else begin
            ovr_event = 1'b1;
         end
      end else if (irq_ack_i) begin
         irq_d = 1'b0;
      end

      if (ovr_clr_i) begin
         overrun_d = ovr_event;
      end else if (ovr_event) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q      <= IDLE;
         timer_res_q  <= 1'b1;
         irq_q        <= 1'b0;
         overrun_q    <= 1'b0;
         div_cnt_q    <= '0;
         tick_total_q <= '0;
      end else begin
         state_q      <= state_d;
         timer_res_q  <= timer_res_d;
         irq_q        <= irq_d;
         overrun_q    <= overrun_d;
         div_cnt_q    <= div_cnt_d;
         tick_total_q <= tick_total_d;
      end
   end

   tick_irq_ctrl_sat_counter #(
      .WIDTH (OVR_W)
   ) u_ovr_cnt (
      .clk   (clk),
      .res_n (res_n),
      .inc_i (ovr_event),
      .clr_i (ovr_clr_i),
      .cnt_o (ovr_cnt_o)
   );

   assign timer_res_o  = timer_res_q;
   assign irq_o        = irq_q;
   assign overrun_o    = overrun_q;
   assign tick_total_o = tick_total_q;

endmodule
